// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: programmable, armable serial pattern detector controller.
// Holds a runtime pattern of up to PAT_W bits and sequences IDLE/FILL/ARMED.
// Each match gives a one-cycle det_out pulse and a valid/ready event with a
// saturating match count.
// Build option: define SEQ_DET_OVERLAP_EN to keep history after a match, so
// that overlapping occurrences are detected. With it undefined, a match
// flushes the history and the next match needs len_r fresh bits.
module seq_det_ctrl #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  parameter int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             arm,
  input  logic             disarm,
  input  logic             seq_in,
  input  logic             seq_vld,
  output logic             det_out,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CNT_W-1:0] evt_count,
  output logic             overflow,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FILL  = 2'b01,
    ST_ARMED = 2'b10
  } state_t;

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

  state_t           r_state;
  logic [PAT_W-1:0] r_pat;
  logic [LEN_W-1:0] r_len;
  logic [PAT_W-1:0] r_hist;
  logic [LEN_W-1:0] r_fill;
  logic             r_det;
  logic             r_evt_valid;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;

  logic [PAT_W-1:0] w_hist_next;
  logic [PAT_W-1:0] w_mask;
  logic [LEN_W:0]   w_fill_inc;
  logic [LEN_W-1:0] w_fill_next;
  logic [LEN_W-1:0] w_len_clamp;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_active;
  logic             w_match;

  // Next history, length mask, fill/count increments and the match decision
  always_comb begin
    w_hist_next = {r_hist[PAT_W-2:0], seq_in};
    w_mask      = {PAT_W{1'b0}};
    for (int i = 0; i < PAT_W; i++) begin
      w_mask[i] = (i < int'(r_len)) ? 1'b1 : 1'b0;
    end
    w_fill_inc = {1'b0, r_fill} + {{LEN_W{1'b0}}, 1'b1};
    if (r_fill < r_len) begin
      w_fill_next = w_fill_inc[LEN_W-1:0];
    end else begin
      w_fill_next = r_fill;
    end
    if (cfg_len > LEN_MAX) begin
      w_len_clamp = LEN_MAX;
    end else begin
      w_len_clamp = cfg_len;
    end
    if (r_cnt == {CNT_W{1'b1}}) begin
      w_cnt_next = r_cnt;
    end else begin
      w_cnt_next = r_cnt + CNT_W'(1);
    end
    w_active = (r_state == ST_FILL) || (r_state == ST_ARMED);
    // A match in the disarm cycle is discarded
    w_match  = w_active && seq_vld && !disarm &&
               (w_fill_inc >= {1'b0, r_len}) &&
               (((w_hist_next ^ r_pat) & w_mask) == {PAT_W{1'b0}});
  end

  // Controller FSM, shift history, event handshake and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_pat       <= {PAT_W{1'b0}};
      r_len       <= {LEN_W{1'b0}};
      r_hist      <= {PAT_W{1'b0}};
      r_fill      <= {LEN_W{1'b0}};
      r_det       <= 1'b0;
      r_evt_valid <= 1'b0;
      r_cnt       <= {CNT_W{1'b0}};
      r_ovf       <= 1'b0;
    end else begin
      r_det <= w_match;

      // Event channel: a new match keeps valid high even if accepted now
      if (w_match) begin
        r_cnt       <= w_cnt_next;
        r_evt_valid <= 1'b1;
        if (r_evt_valid && !evt_ready) begin
          r_ovf <= 1'b1;
        end
      end else if (r_evt_valid && evt_ready) begin
        r_evt_valid <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (disarm) begin
            r_hist <= {PAT_W{1'b0}};
            r_fill <= {LEN_W{1'b0}};
          end else begin
            if (cfg_we) begin
              r_pat <= cfg_pattern;
              r_len <= w_len_clamp;
            end
            // Arm uses the length already held, not one written this cycle
            if (arm && (r_len != {LEN_W{1'b0}})) begin
              r_hist      <= {PAT_W{1'b0}};
              r_fill      <= {LEN_W{1'b0}};
              r_cnt       <= {CNT_W{1'b0}};
              r_ovf       <= 1'b0;
              r_evt_valid <= 1'b0;
              r_state     <= ST_FILL;
            end
          end
        end
        ST_FILL, ST_ARMED: begin
          if (disarm) begin
            r_hist  <= {PAT_W{1'b0}};
            r_fill  <= {LEN_W{1'b0}};
            r_state <= ST_IDLE;
          end else if (seq_vld) begin
`ifdef SEQ_DET_OVERLAP_EN
            r_hist <= w_hist_next;
            r_fill <= w_fill_next;
            if (w_fill_next == r_len) begin
              r_state <= ST_ARMED;
            end
`else
            if (w_match) begin
              r_hist  <= {PAT_W{1'b0}};
              r_fill  <= {LEN_W{1'b0}};
              r_state <= ST_FILL;
            end else begin
              r_hist <= w_hist_next;
              r_fill <= w_fill_next;
              if (w_fill_next == r_len) begin
                r_state <= ST_ARMED;
              end
            end
`endif
          end
        end
        default: begin
          r_hist  <= {PAT_W{1'b0}};
          r_fill  <= {LEN_W{1'b0}};
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign det_out   = r_det;
  assign evt_valid = r_evt_valid;
  assign evt_count = r_cnt;
  assign overflow  = r_ovf;
  assign state     = r_state;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed self-checking bench for seq_det_ctrl (PAT_W=8, CNT_W=8).
// Expected values are hand-derived for both SEQ_DET_OVERLAP_EN builds.
module tb_seq_det_ctrl;

  localparam int PAT_W = 8;
  localparam int CNT_W = 8;
  localparam int LEN_W = 4;

  logic             clk;
  logic             reset;
  logic             cfg_we;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             arm;
  logic             disarm;
  logic             seq_in;
  logic             seq_vld;
  logic             det_out;
  logic             evt_valid;
  logic             evt_ready;
  logic [CNT_W-1:0] evt_count;
  logic             overflow;
  logic [1:0]       state;

  int n_checks = 0;
  int n_errors = 0;

  seq_det_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .arm(arm), .disarm(disarm), .seq_in(seq_in),
    .seq_vld(seq_vld), .det_out(det_out), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_count(evt_count), .overflow(overflow),
    .state(state)
  );

  // Free-running 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One clock, then settle 1 ns past the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_cfg(input logic [PAT_W-1:0] pat, input logic [LEN_W-1:0] len);
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_we      = 1'b1;
    step();
    cfg_we      = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic pulse_disarm();
    disarm = 1'b1;
    step();
    disarm = 1'b0;
  endtask

  // Send n bits, first bit = bits[n-1]; check det_out after every bit
  task automatic send_bits(input string tag, input logic [15:0] bits,
                           input int n, input logic [15:0] exp_det);
    for (int i = n - 1; i >= 0; i--) begin
      seq_in  = bits[i];
      seq_vld = 1'b1;
      step();
      seq_vld = 1'b0;
      check_val($sformatf("%s_det%0d", tag, n - i), {31'd0, det_out}, {31'd0, exp_det[i]});
    end
  endtask

  initial begin
    reset = 1'b0; cfg_we = 1'b0; cfg_pattern = 8'h00; cfg_len = 4'd0;
    arm = 1'b0; disarm = 1'b0; seq_in = 1'b0; seq_vld = 1'b0; evt_ready = 1'b0;
    step();
    step();
    check_val("rst_state", {30'd0, state}, 32'd0);
    check_val("rst_det", {31'd0, det_out}, 32'd0);
    check_val("rst_valid", {31'd0, evt_valid}, 32'd0);
    check_val("rst_count", {24'd0, evt_count}, 32'd0);
    check_val("rst_ovf", {31'd0, overflow}, 32'd0);
    reset = 1'b1;
    step();

    // Pattern 1011, len 4; evt_ready held low across matches
    load_cfg(8'h0B, 4'd4);
    pulse_arm();
    check_val("arm_state", {30'd0, state}, 32'd1);
`ifdef SEQ_DET_OVERLAP_EN
    send_bits("seq7", 16'b1011011, 7, 16'b0001001);
    check_val("seq7_count", {24'd0, evt_count}, 32'd2);
    check_val("seq7_state", {30'd0, state}, 32'd2);
    check_val("seq7_ovf", {31'd0, overflow}, 32'd1);
`else
    send_bits("seq7", 16'b1011011, 7, 16'b0001000);
    check_val("seq7_count", {24'd0, evt_count}, 32'd1);
    check_val("seq7_state", {30'd0, state}, 32'd1);
    check_val("seq7_ovf", {31'd0, overflow}, 32'd0);
`endif
    send_bits("more", 16'b1011, 4, 16'b0001);
`ifdef SEQ_DET_OVERLAP_EN
    check_val("more_count", {24'd0, evt_count}, 32'd3);
`else
    check_val("more_count", {24'd0, evt_count}, 32'd2);
`endif
    check_val("more_valid", {31'd0, evt_valid}, 32'd1);
    check_val("more_ovf", {31'd0, overflow}, 32'd1);

    // One-cycle accept clears valid; overflow is sticky
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    check_val("acc_valid", {31'd0, evt_valid}, 32'd0);
    check_val("acc_ovf", {31'd0, overflow}, 32'd1);

    // Re-arm clears the event state
    pulse_disarm();
    check_val("dis_state", {30'd0, state}, 32'd0);
    check_val("dis_valid", {31'd0, evt_valid}, 32'd0);
    pulse_arm();
    check_val("rearm_ovf", {31'd0, overflow}, 32'd0);
    check_val("rearm_count", {24'd0, evt_count}, 32'd0);
    send_bits("m1", 16'b1011, 4, 16'b0001);
    check_val("m1_valid", {31'd0, evt_valid}, 32'd1);

    // Accept in the same cycle as a new match: valid stays, no overflow
    send_bits("m2a", 16'b101, 3, 16'b000);
    evt_ready = 1'b1;
    send_bits("m2b", 16'b1, 1, 16'b1);
    evt_ready = 1'b0;
    check_val("m2_valid", {31'd0, evt_valid}, 32'd1);
    check_val("m2_ovf", {31'd0, overflow}, 32'd0);
    check_val("m2_count", {24'd0, evt_count}, 32'd2);

    // Disarm on the completing bit discards the match
    send_bits("d1", 16'b101, 3, 16'b000);
    disarm = 1'b1;
    send_bits("d2", 16'b1, 1, 16'b0);
    disarm = 1'b0;
    check_val("d_state", {30'd0, state}, 32'd0);
    check_val("d_count", {24'd0, evt_count}, 32'd2);
    check_val("d_valid", {31'd0, evt_valid}, 32'd1);

    // Length 12 clamps to 8: 8-bit pattern A5 matches on the 8th bit
    load_cfg(8'hA5, 4'd12);
    pulse_arm();
    send_bits("cl7", 16'b1010010, 7, 16'b0000000);
    check_val("cl7_state", {30'd0, state}, 32'd1);
    send_bits("cl8", 16'b1, 1, 16'b1);
    check_val("cl8_count", {24'd0, evt_count}, 32'd1);
`ifdef SEQ_DET_OVERLAP_EN
    check_val("cl8_state", {30'd0, state}, 32'd2);
`else
    check_val("cl8_state", {30'd0, state}, 32'd1);
`endif

    // Arm with length 0 is ignored
    pulse_disarm();
    load_cfg(8'h0B, 4'd0);
    pulse_arm();
    check_val("len0_state", {30'd0, state}, 32'd0);

    // cfg_we while active is ignored; old pattern 1011 still matches
    load_cfg(8'h0B, 4'd4);
    pulse_arm();
    load_cfg(8'h00, 4'd4);
    send_bits("cw", 16'b1011, 4, 16'b0001);
    check_val("cw_count", {24'd0, evt_count}, 32'd1);

    // Count saturates at all-ones under a long run of matches
    pulse_disarm();
    load_cfg(8'h0F, 4'd4);
    pulse_arm();
    evt_ready = 1'b1;
    seq_in    = 1'b1;
    seq_vld   = 1'b1;
    for (int i = 0; i < 1100; i++) begin
      step();
    end
    seq_vld   = 1'b0;
    step();
    check_val("sat_count", {24'd0, evt_count}, 32'd255);
    check_val("sat_det_end", {31'd0, det_out}, 32'd0);

    // Asynchronous reset mid-operation clears everything
    #3;
    reset = 1'b0;
    #1;
    check_val("arst_state", {30'd0, state}, 32'd0);
    check_val("arst_count", {24'd0, evt_count}, 32'd0);
    check_val("arst_valid", {31'd0, evt_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
